snake_colour_engine: RTL and testbench

Parametrised pixel-colour generator for the snake VGA game, sitting between the object/map lookup and the VGA sync/output stage. It classifies each scanned pixel as active-area, target (apple) cell or map object. It produces a registered RGB colour from a reset-initialised palette. It also runs frame-synchronous effects: an animated WIN gradient and a blinking FAIL screen. Unlike the previous generation, colour depth, screen size, cell size and palette size are parameters, and the output is fully pipelined with a valid flag.

---
 rtl/snake_colour_engine.sv | 153 +++++++++++++++
 tb/tb_snake_colour_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_colour_engine.sv
// snake_colour_engine: two-stage pixel colour pipeline (classify, then colour) for the snake VGA game.
// Optional feature: define COLOUR_PAL_WR_EN to make the palette writable through pal_wr_*.
module snake_colour_engine #(
    parameter int COLOUR_W     = 4,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_W          = 10,
    parameter int V_W          = 9,
    parameter int CELL_SHIFT   = 2,
    parameter int OBJ_W        = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [1:0]                                     msm_state,
    input  logic [(H_W-CELL_SHIFT)+(V_W-CELL_SHIFT)-1:0]   target_addr,
    input  logic [OBJ_W-1:0]                               object,
    input  logic [H_W-1:0]                                 addrh,
    input  logic [V_W-1:0]                                 addrv,
    input  logic                                           pal_wr_en,
    input  logic [OBJ_W-1:0]                               pal_wr_idx,
    input  logic [3*COLOUR_W-1:0]                          pal_wr_data,
    output logic [3*COLOUR_W-1:0]                          colour_out,
    output logic                                           colour_valid
);
    localparam int HC_W  = H_W - CELL_SHIFT;
    localparam int VC_W  = V_W - CELL_SHIFT;
    localparam int CW3   = 3 * COLOUR_W;
    localparam int PAL_N = 2 ** OBJ_W;
    localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COLOUR_W-1:0] CMAX    = '1;
    localparam logic [COLOUR_W-1:0] CZERO   = '0;
    localparam logic [CW3-1:0]      RED     = {CMAX, CZERO, CZERO};
    localparam logic [H_W-1:0]      H_LAST  = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0]      V_LAST  = V_W'(V_ACTIVE - 1);
    localparam logic [BC_W-1:0]     BC_LAST = BC_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_PLAY = 2'b01, ST_WIN = 2'b10, ST_FAIL = 2'b11} msm_e;
    typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_e;

    function automatic logic [CW3-1:0] palDefault(input int idx);
        case (idx)
            1:       palDefault = {CZERO, CMAX, CZERO};
            2:       palDefault = {CZERO, CMAX, CMAX};
            3:       palDefault = {CMAX, CZERO, CMAX};
            4:       palDefault = {CMAX, CMAX, CMAX};
            default: palDefault = '0;
        endcase
    endfunction

    logic           frameTick;
    logic           active_d, hit_d;
    logic [7:0]     g_d;
    logic           active_q, hit_q;
    logic [7:0]     g_q;
    logic [OBJ_W-1:0] obj_q;
    msm_e           msm_q;
    logic [15:0]    frameCnt_q;
    logic [BC_W-1:0] blinkCnt_q;
    phase_e         phase_q;
    logic [CW3-1:0] palRead;
    logic [CW3-1:0] colour_d;
    logic [7:0]     gGreen, gBlue;

    assign frameTick = (addrh == H_LAST) && (addrv == V_LAST);
    assign active_d  = ({1'b0, addrh} < (H_W+1)'(H_ACTIVE)) && ({1'b0, addrv} < (V_W+1)'(V_ACTIVE));
    assign hit_d     = (addrh[H_W-1:CELL_SHIFT] == target_addr[HC_W+VC_W-1:VC_W]) &&
                       (addrv[V_W-1:CELL_SHIFT] == target_addr[VC_W-1:0]);
    assign g_d       = frameCnt_q[15:8] + addrh[7:0] + addrv[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            hit_q      <= 1'b0;
            g_q        <= '0;
            obj_q      <= '0;
            msm_q      <= ST_IDLE;
            frameCnt_q <= '0;
        end else begin
            active_q <= active_d;
            hit_q    <= hit_d;
            g_q      <= g_d;
            obj_q    <= object;
            msm_q    <= msm_e'(msm_state);
            if (frameTick)
                frameCnt_q <= frameCnt_q + 16'd1;
        end
    end

    // Leaving FAIL always wins over a coincident frame tick, so each FAIL entry starts red.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= PH_ON;
            blinkCnt_q <= '0;
        end else if (msm_state != ST_FAIL) begin
            phase_q    <= PH_ON;
            blinkCnt_q <= '0;
        end else if (frameTick) begin
            if (blinkCnt_q == BC_LAST) begin
                blinkCnt_q <= '0;
                phase_q    <= (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blinkCnt_q <= blinkCnt_q + BC_W'(1);
            end
        end
    end

`ifdef COLOUR_PAL_WR_EN
    logic [CW3-1:0] pal_q [PAL_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_N; i++)
                pal_q[i] <= palDefault(i);
        end else if (pal_wr_en) begin
            pal_q[pal_wr_idx] <= pal_wr_data;
        end
    end

    assign palRead = pal_q[obj_q];
`else
    logic unused_palWr;
    assign unused_palWr = ^{pal_wr_en, pal_wr_idx, pal_wr_data};
    assign palRead      = palDefault(int'(obj_q));
`endif

    always_comb begin
        gGreen   = g_q + 8'd85;
        gBlue    = g_q + 8'd170;
        colour_d = '0;
        if (active_q) begin
            case (msm_q)
                ST_IDLE: colour_d = {CZERO, CMAX, CZERO};
                ST_PLAY: colour_d = hit_q ? RED : palRead;
                ST_WIN:  colour_d = {g_q[7-:COLOUR_W], gGreen[7-:COLOUR_W], gBlue[7-:COLOUR_W]};
                ST_FAIL: colour_d = (phase_q == PH_ON) ? RED : '0;
                default: colour_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colour_out   <= '0;
            colour_valid <= 1'b0;
        end else begin
            colour_out   <= colour_d;
            colour_valid <= active_q;
        end
    end

endmodule

// File: tb/tb_snake_colour_engine.sv
// tb_snake_colour_engine: random and directed pixels checked every cycle against a frame-level colour model.
// Follows COLOUR_PAL_WR_EN so palette writes are modelled only when the design honours them.
module tb_snake_colour_engine;
    localparam int BLINK = 2;

    typedef struct packed {
        logic        valid;
        logic [11:0] col;
        logic        hasLit;
        logic        litValid;
        logic [11:0] litCol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  msm_state = 2'b00;
    logic [14:0] target_addr = '0;
    logic [2:0]  object = '0;
    logic [9:0]  addrh = 10'd700;
    logic [8:0]  addrv = '0;
    logic        pal_wr_en = 1'b0;
    logic [2:0]  pal_wr_idx = '0;
    logic [11:0] pal_wr_data = '0;
    logic [11:0] colour_out;
    logic        colour_valid;

    int   vectors = 0;
    int   miscompares = 0;
    bit   cmpEn = 1'b0;
    exp_t expQ[$];

    int          mFrame;
    int          mBlink;
    bit          mOff;
    logic [11:0] mPal [8];

    snake_colour_engine #(.BLINK_FRAMES(BLINK)) dut (
        .clk(clk), .rst_n(rst_n), .msm_state(msm_state), .target_addr(target_addr),
        .object(object), .addrh(addrh), .addrv(addrv), .pal_wr_en(pal_wr_en),
        .pal_wr_idx(pal_wr_idx), .pal_wr_data(pal_wr_data),
        .colour_out(colour_out), .colour_valid(colour_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic gotV, input logic [11:0] gotC,
                               input logic expV, input logic [11:0] expC);
        vectors++;
        if (gotV !== expV || gotC !== expC) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got valid=%0b colour=%03h, expected valid=%0b colour=%03h",
                     name, $time, gotV, gotC, expV, expC);
        end
    endtask

    task automatic modelReset();
        mFrame = 0;
        mBlink = 0;
        mOff   = 1'b0;
        for (int i = 0; i < 8; i++) mPal[i] = 12'h000;
        mPal[1] = 12'h0F0;
        mPal[2] = 12'h0FF;
        mPal[3] = 12'hF0F;
        mPal[4] = 12'hFFF;
    endtask

    // One pixel per clock; the expected result lands in the queue two compare slots ahead.
    task automatic applyStimulus(input int msm, input int obj, input int h, input int v, input int tgt,
                                 input bit wen, input int widx, input logic [11:0] wdata,
                                 input bit hasLit, input bit litValid, input logic [11:0] litCol);
        exp_t e;
        int   g;
        bit   tick, hit;
        @(posedge clk);
        #2;
        msm_state   = 2'(msm);
        object      = 3'(obj);
        addrh       = 10'(h);
        addrv       = 9'(v);
        target_addr = 15'(tgt);
        pal_wr_en   = wen;
        pal_wr_idx  = 3'(widx);
        pal_wr_data = wdata;

        g    = ((mFrame / 256) + (h % 256) + (v % 256)) % 256;
        tick = (h == 639) && (v == 479);
`ifdef COLOUR_PAL_WR_EN
        if (wen) mPal[widx] = wdata;
`endif
        if (msm != 3) begin
            mBlink = 0;
            mOff   = 1'b0;
        end else if (tick) begin
            mBlink++;
            if (mBlink == BLINK) begin
                mBlink = 0;
                mOff   = !mOff;
            end
        end
        if (tick) mFrame = (mFrame + 1) % 65536;

        e.valid = (h < 640) && (v < 480);
        hit     = (h / 4 == tgt / 128) && (v / 4 == tgt % 128);
        e.col   = 12'h000;
        if (e.valid) begin
            case (msm)
                0: e.col = 12'h0F0;
                1: e.col = hit ? 12'hF00 : mPal[obj];
                2: e.col = {4'(g / 16), 4'(((g + 85) % 256) / 16), 4'(((g + 170) % 256) / 16)};
                default: e.col = mOff ? 12'h000 : 12'hF00;
            endcase
        end
        e.hasLit   = hasLit;
        e.litValid = litValid;
        e.litCol   = litCol;
        expQ.push_back(e);
        cmpEn = 1'b1;
    endtask

    task automatic doReset();
        exp_t z;
        @(posedge clk);
        #3;
        cmpEn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", colour_valid, colour_out, 1'b0, 12'h000);
        msm_state = 2'b00;
        addrh     = 10'd700;
        addrv     = 9'd0;
        pal_wr_en = 1'b0;
        modelReset();
        expQ.delete();
        z = '0;
        expQ.push_back(z);
        expQ.push_back(z);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic randomPixels(input int n, input bit winOnly);
        int h, v, msm, tgt;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                h = 639;
                v = 479;
            end else begin
                h = $urandom_range(0, 799);
                v = $urandom_range(0, 511);
            end
            msm = winOnly ? 2 : int'($urandom_range(0, 3));
            tgt = ($urandom_range(0, 1) == 0) ? ((h / 4) % 256) * 128 + (v / 4) % 128
                                              : int'($urandom_range(0, 32767));
            applyStimulus(msm, $urandom_range(0, 7), h, v, tgt, ($urandom_range(0, 9) == 0),
                          $urandom_range(0, 7), 12'($urandom), 1'b0, 1'b0, 12'h000);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cmpEn) begin
            if (expQ.size() == 0) begin
                checkOutput("queueEmpty", colour_valid, colour_out, 1'bx, 12'hxxx);
            end else begin
                e = expQ.pop_front();
                checkOutput("model", colour_valid, colour_out, e.valid, e.col);
                if (e.hasLit)
                    checkOutput("literal", colour_valid, colour_out, e.litValid, e.litCol);
            end
        end
    end

    initial begin
        logic [11:0] bodyNew;
`ifdef COLOUR_PAL_WR_EN
        bodyNew = 12'h123;
`else
        bodyNew = 12'h0FF;
`endif
        modelReset();
        doReset();

        applyStimulus(1, 3, 100, 100, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'hF0F);
        applyStimulus(1, 3, 700, 100, 0, 1'b0, 0, 12'h000, 1'b1, 1'b0, 12'h000);
        applyStimulus(1, 1, 101, 102, 3225, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'hF00);
        applyStimulus(1, 1, 104, 102, 3225, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'h0F0);

        applyStimulus(1, 2, 300, 300, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'h0FF);
        applyStimulus(1, 2, 300, 300, 0, 1'b1, 2, 12'h123, 1'b1, 1'b1, bodyNew);
        applyStimulus(1, 2, 301, 300, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, bodyNew);

        for (int i = 0; i < 768; i++)
            applyStimulus(0, 0, 639, 479, 0, 1'b0, 0, 12'h000, 1'b0, 1'b0, 12'h000);
        applyStimulus(2, 0, 16, 32, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'h38D);

        // Six FAIL frames with BLINK_FRAMES=2: red, red, black, black, red, red.
        for (int f = 0; f < 6; f++) begin
            applyStimulus(3, 0, 200, 200, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1,
                          (f == 2 || f == 3) ? 12'h000 : 12'hF00);
            applyStimulus(3, 0, 639, 479, 0, 1'b0, 0, 12'h000, 1'b0, 1'b0, 12'h000);
        end
        applyStimulus(3, 0, 200, 200, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'h000);
        applyStimulus(0, 0, 200, 200, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'h0F0);
        applyStimulus(3, 0, 200, 200, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'hF00);

        randomPixels(2500, 1'b0);
        randomPixels(5, 1'b1);
        applyStimulus(2, 0, 64, 5, 0, 1'b0, 0, 12'h000, 1'b0, 1'b0, 12'h000);
        doReset();

        applyStimulus(1, 2, 300, 300, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'h0FF);
        applyStimulus(2, 0, 64, 0, 0, 1'b0, 0, 12'h000, 1'b1, 1'b1, 12'h49E);
        randomPixels(1000, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        cmpEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
